registro_pipeline_elastico: RTL and testbench
=============================================

// Module: registro_pipeline_elastico
// PURPOSE
//  Parametrised elastic pipeline register: D stages of W-bit data, each with its own valid bit,
//  valid/ready handshake on both sides, global Enable (freeze) and Flush. Inserted between
//  datapath blocks to add retiming latency without dropping data under downstream back-pressure.
//  Next-generation register stage: generalises the fixed two-deep enabled register.
// PARAMETERS
//  W  12  data width in bits (>=1)
//  D  2   number of pipeline stages (>=1); latency in cycles when unstalled
// PORTS
//  CLK           in   1          clock; all state updates on posedge
//  Reset         in   1          synchronous, active-high reset
//  Enable        in   1          1 = pipeline may move; 0 = freeze all stages, in_ready=0, out_valid held
//  Flush         in   1          synchronous clear of all valid bits (data regs untouched)
//  in_valid      in   1          Entrada holds a word
//  in_ready      out  1          stage 0 can accept this cycle
//  Entrada       in   W          input word
//  out_valid     out  1          Salida holds a word (= valid of stage D-1)
//  out_ready     in   1          consumer takes Salida this cycle
//  Salida        out  W          output word (= data of stage D-1, registered)
//  Ocupacion     out  clog2(D+1) words held (only with REGISTRO_OCUPACION_EN)
//  Lleno, Vacio  out  1          Ocupacion==D / Ocupacion==0 (only with REGISTRO_OCUPACION_EN)
// BEHAVIOUR
//  - State: data[i] (W bits), v[i] (1 bit), i = 0..D-1. Stage 0 nearest input.
//  - Reset: all v[i]=0, all data[i]=0; hence out_valid=0, Salida=0, in_ready=0 while Reset=1,
//    Ocupacion=0, Vacio=1, Lleno=0. Reset has priority over Flush and Enable.
//  - Move rule (Enable=1): mv[D-1] = v[D-1] & out_ready; mv[i] = v[i] & (!v[i+1] | mv[i+1]).
//    Stage i+1 loads data[i] and sets v when mv[i]; a stage that sends and does not receive clears v.
//  - in_ready = Enable & !Reset & (!v[0] | mv[0]); combinational through the ready chain
//    (out_ready -> in_ready path is intentional; no skid buffer).
//  - Accept = in_valid & in_ready: data[0] <= Entrada, v[0] <= 1 next edge.
//  - Latency: word accepted at edge k appears with out_valid=1 after edge k+D-1 (D cycles
//    from presentation) when unstalled. Throughput 1 word/cycle with out_ready held 1.
//  - Back-pressure: out_ready=0 fills bubbles first; stages compress; in_ready falls only when
//    all D stages valid. No word is lost, duplicated or reordered.
//  - Bubble: v[i]=0 stages carry stale data; data regs of invalid stages are don't-care but
//    Salida only changes on a load of stage D-1.
//  - Enable=0: no register changes (data and v held), in_ready=0, out_valid reflects held v;
//    a consumer asserting out_ready while Enable=0 does NOT consume.
//  - Flush=1 (Reset=0): next edge all v[i]=0 regardless of Enable, in_valid, out_ready;
//    in_ready forced 0 during the Flush cycle; input word that cycle is dropped.
//  - Reset mid-stream: all in-flight words discarded, state as reset above.
// CONFIGURATION
//  REGISTRO_OCUPACION_EN defined: adds registered Ocupacion counter (+1 on accept, -1 on
//    consume, unchanged on both/neither, 0 on Reset/Flush) and Lleno/Vacio flags from it;
//    counter must always equal popcount(v). Undefined: ports Ocupacion/Lleno/Vacio absent,
//    no counter logic; all other behaviour identical.
// TESTING
//  T1 W=12,D=2, out_ready=1, stream 0x001..0x00A one per cycle -> Salida same sequence, each
//     word out_valid 2 cycles after presentation, no gaps.
//  T2 D=4, fill 4 words with out_ready=0 -> in_ready=0 after 4th accept, Ocupacion=4, Lleno=1;
//     raise out_ready -> words out in order, in_ready=1 same cycle as first consume.
//  T3 random in_valid/out_ready (50%) 10k cycles vs reference queue model -> zero loss/dup/reorder,
//     Ocupacion==popcount(v) every cycle.
//  T4 D=3, 3 words in flight, Enable=0 for 5 cycles with out_ready=1 -> Salida/out_valid frozen,
//     nothing consumed; Enable=1 -> resume, all 3 delivered.
//  T5 Flush with 2 words in flight and in_valid=1 -> next cycle out_valid=0, Ocupacion=0,
//     flushed-cycle input absent from output.
//  T6 Reset asserted mid-stream (with Enable=0 and Flush=1 simultaneously) -> next edge
//     Salida=0x000, out_valid=0, Vacio=1; in_ready=0 while Reset=1.

Source files
------------

// File: rtl/registro_pipeline_elastico_if.sv
// Handshake bundle for the elastic pipeline register: input side (in_valid/in_ready/Entrada)
// and output side (out_valid/out_ready/Salida). The master modport is the surrounding datapath's view.
interface registro_pipeline_elastico_if #(
    parameter int W = 12
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Entrada;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Salida;

    modport master (
        output in_valid, Entrada, out_ready,
        input  in_ready, out_valid, Salida
    );

    modport slave (
        input  in_valid, Entrada, out_ready,
        output in_ready, out_valid, Salida
    );
endinterface

// File: rtl/registro_pipeline_elastico.sv
// Elastic pipeline register: D stages of W-bit data with per-stage valid, valid/ready on both sides,
// global Enable (freeze) and Flush. Optional occupancy counter enabled by macro REGISTRO_OCUPACION_EN.
module registro_pipeline_elastico #(
    parameter int W = 12,
    parameter int D = 2
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      Enable,
    input  logic                      Flush,
    registro_pipeline_elastico_if.slave bus
`ifdef REGISTRO_OCUPACION_EN
    ,
    output logic [$clog2(D+1)-1:0]    Ocupacion,
    output logic                      Lleno,
    output logic                      Vacio
`endif
);

    logic [D-1:0][W-1:0] data_q;
    logic [D-1:0][W-1:0] data_d;
    logic [D-1:0][W-1:0] src_s;
    logic [D-1:0]        v_q;
    logic [D-1:0]        v_d;
    logic [D-1:0]        mv_s;
    logic [D-1:0]        load_s;
    logic                move_en_s;
    logic                in_ready_s;
    logic                accept_s;

    // Ready chain from the output back to stage 0; Flush and Reset block every move
    always_comb begin
        move_en_s = Enable & ~Flush & ~Reset;
        mv_s      = '0;
        mv_s[D-1] = move_en_s & v_q[D-1] & bus.out_ready;
        for (int i = D - 2; i >= 0; i--) begin
            mv_s[i] = move_en_s & v_q[i] & (~v_q[i+1] | mv_s[i+1]);
        end
        in_ready_s = move_en_s & (~v_q[0] | mv_s[0]);
        accept_s   = bus.in_valid & in_ready_s;
    end

    // Per-stage load strobe and source word (stage 0 loads from the input)
    always_comb begin
        load_s    = '0;
        src_s     = '0;
        load_s[0] = accept_s;
        src_s[0]  = bus.Entrada;
        for (int i = 1; i < D; i++) begin
            load_s[i] = mv_s[i-1];
            src_s[i]  = data_q[i-1];
        end
    end

    // Next stage state: load wins over send; a stage that only sends becomes a bubble
    always_comb begin
        data_d = data_q;
        v_d    = v_q;
        if (Reset) begin
            data_d = '0;
            v_d    = '0;
        end else if (Flush) begin
            v_d = '0;
        end else begin
            for (int i = 0; i < D; i++) begin
                if (load_s[i]) begin
                    data_d[i] = src_s[i];
                    v_d[i]    = 1'b1;
                end else if (mv_s[i]) begin
                    v_d[i] = 1'b0;
                end else begin
                    v_d[i] = v_q[i];
                end
            end
        end
    end

    // Stage registers
    always_ff @(posedge CLK) begin
        data_q <= data_d;
        v_q    <= v_d;
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = v_q[D-1];
    assign bus.Salida    = data_q[D-1];

`ifdef REGISTRO_OCUPACION_EN
    localparam int OCW = $clog2(D + 1);

    logic [OCW-1:0] ocup_q;
    logic [OCW-1:0] ocup_d;
    logic           lleno_q;
    logic           lleno_d;
    logic           vacio_q;
    logic           vacio_d;

    // Occupancy tracks accepts minus consumes so it always equals the number of valid stages
    always_comb begin
        ocup_d = ocup_q;
        if (Reset | Flush) begin
            ocup_d = '0;
        end else if (accept_s & ~mv_s[D-1]) begin
            ocup_d = ocup_q + OCW'(1);
        end else if (~accept_s & mv_s[D-1]) begin
            ocup_d = ocup_q - OCW'(1);
        end else begin
            ocup_d = ocup_q;
        end
        lleno_d = (ocup_d == OCW'(D));
        vacio_d = (ocup_d == '0);
    end

    // Occupancy and flag registers
    always_ff @(posedge CLK) begin
        ocup_q  <= ocup_d;
        lleno_q <= lleno_d;
        vacio_q <= vacio_d;
    end

    assign Ocupacion = ocup_q;
    assign Lleno     = lleno_q;
    assign Vacio     = vacio_q;
`endif

endmodule

// File: tb/tb_registro_pipeline_elastico.sv
// Self-checking bench for registro_pipeline_elastico: table-driven stream, directed corner sequences
// and a randomized run against a queue reference model; three instances with D=2, 3 and 4.
module tb_registro_pipeline_elastico;

    logic CLK = 1'b0;
    logic Reset;
    logic Enable;
    logic Flush;

    int checks = 0;
    int errors = 0;

    registro_pipeline_elastico_if #(.W(12)) if2 ();
    registro_pipeline_elastico_if #(.W(12)) if3 ();
    registro_pipeline_elastico_if #(.W(12)) if4 ();

`ifdef REGISTRO_OCUPACION_EN
    logic [1:0] ocup2;
    logic [1:0] ocup3;
    logic [2:0] ocup4;
    logic       lleno2, lleno3, lleno4;
    logic       vacio2, vacio3, vacio4;
`endif

    registro_pipeline_elastico #(.W(12), .D(2)) u_d2 (
        .CLK(CLK), .Reset(Reset), .Enable(Enable), .Flush(Flush), .bus(if2)
`ifdef REGISTRO_OCUPACION_EN
        , .Ocupacion(ocup2), .Lleno(lleno2), .Vacio(vacio2)
`endif
    );

    registro_pipeline_elastico #(.W(12), .D(3)) u_d3 (
        .CLK(CLK), .Reset(Reset), .Enable(Enable), .Flush(Flush), .bus(if3)
`ifdef REGISTRO_OCUPACION_EN
        , .Ocupacion(ocup3), .Lleno(lleno3), .Vacio(vacio3)
`endif
    );

    registro_pipeline_elastico #(.W(12), .D(4)) u_d4 (
        .CLK(CLK), .Reset(Reset), .Enable(Enable), .Flush(Flush), .bus(if4)
`ifdef REGISTRO_OCUPACION_EN
        , .Ocupacion(ocup4), .Lleno(lleno4), .Vacio(vacio4)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        iv;
        logic [11:0] ent;
        logic        ordy;
        logic        e_ov;
        logic [11:0] e_sal;
        logic        e_ir;
    } vec_t;

    vec_t t1 [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_all();
        if2.in_valid = 1'b0; if2.Entrada = 12'h000; if2.out_ready = 1'b0;
        if3.in_valid = 1'b0; if3.Entrada = 12'h000; if3.out_ready = 1'b0;
        if4.in_valid = 1'b0; if4.Entrada = 12'h000; if4.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        Reset  = 1'b1;
        Enable = 1'b1;
        Flush  = 1'b0;
        idle_all();
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned q[$];
        int          n;
        logic        exp_ir;
        logic        iv, ordy, en;

        // Reset state
        Reset  = 1'b1;
        Enable = 1'b1;
        Flush  = 1'b0;
        idle_all();
        if2.in_valid = 1'b1;
        #1;
        chk("rst_in_ready_d2", if2.in_ready, 1'b0);
        tick();
        chk("rst_in_ready_d2_b", if2.in_ready, 1'b0);
        chk("rst_out_valid_d2", if2.out_valid, 1'b0);
        chk("rst_salida_d2", if2.Salida, 12'h000);
        chk("rst_out_valid_d4", if4.out_valid, 1'b0);
`ifdef REGISTRO_OCUPACION_EN
        chk("rst_ocup_d2", ocup2, 2'd0);
        chk("rst_vacio_d2", vacio2, 1'b1);
        chk("rst_lleno_d2", lleno2, 1'b0);
`endif
        do_reset();

        // T1: stream 0x001..0x00A through D=2 with out_ready held high
        for (int k = 0; k < 13; k++) begin
            t1[k].iv    = (k < 10);
            t1[k].ent   = (k < 10) ? 12'(k + 1) : 12'h000;
            t1[k].ordy  = 1'b1;
            t1[k].e_ov  = (k >= 2) && (k <= 11);
            t1[k].e_sal = (k < 2) ? 12'h000 : ((k <= 11) ? 12'(k - 1) : 12'h00A);
            t1[k].e_ir  = 1'b1;
        end
        for (int k = 0; k < 13; k++) begin
            if2.in_valid  = t1[k].iv;
            if2.Entrada   = t1[k].ent;
            if2.out_ready = t1[k].ordy;
            #1;
            chk($sformatf("t1_in_ready_%0d", k), if2.in_ready, t1[k].e_ir);
            chk($sformatf("t1_out_valid_%0d", k), if2.out_valid, t1[k].e_ov);
            chk($sformatf("t1_salida_%0d", k), if2.Salida, t1[k].e_sal);
            tick();
        end

        // T2: fill D=4 under back-pressure, then drain in order
        do_reset();
        for (int j = 0; j < 4; j++) begin
            if4.in_valid = 1'b1;
            if4.Entrada  = 12'(12'h101 + j);
            #1;
            chk("t2_fill_in_ready", if4.in_ready, 1'b1);
            tick();
        end
        if4.Entrada = 12'h105;
        #1;
        chk("t2_full_in_ready", if4.in_ready, 1'b0);
        chk("t2_full_out_valid", if4.out_valid, 1'b1);
        chk("t2_full_salida", if4.Salida, 12'h101);
`ifdef REGISTRO_OCUPACION_EN
        chk("t2_ocup", ocup4, 3'd4);
        chk("t2_lleno", lleno4, 1'b1);
`endif
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b1;
        #1;
        chk("t2_in_ready_on_consume", if4.in_ready, 1'b1);
        for (int j = 0; j < 4; j++) begin
            chk("t2_drain_out_valid", if4.out_valid, 1'b1);
            chk("t2_drain_salida", if4.Salida, 12'(12'h101 + j));
            tick();
        end
        chk("t2_drained_out_valid", if4.out_valid, 1'b0);

        // T4: freeze D=3 with three words in flight
        do_reset();
        for (int j = 0; j < 3; j++) begin
            if3.in_valid = 1'b1;
            if3.Entrada  = 12'(12'h201 + j);
            tick();
        end
        Enable        = 1'b0;
        if3.out_ready = 1'b1;
        if3.Entrada   = 12'h2FF;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("t4_frz_in_ready", if3.in_ready, 1'b0);
            chk("t4_frz_out_valid", if3.out_valid, 1'b1);
            chk("t4_frz_salida", if3.Salida, 12'h201);
`ifdef REGISTRO_OCUPACION_EN
            chk("t4_frz_ocup", ocup3, 2'd3);
`endif
            tick();
        end
        Enable       = 1'b1;
        if3.in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("t4_res_out_valid", if3.out_valid, 1'b1);
            chk("t4_res_salida", if3.Salida, 12'(12'h201 + j));
            tick();
        end
        chk("t4_res_empty", if3.out_valid, 1'b0);

        // T5: flush D=4 with two words in flight and a word presented
        do_reset();
        for (int j = 0; j < 2; j++) begin
            if4.in_valid = 1'b1;
            if4.Entrada  = 12'(12'h301 + j);
            tick();
        end
        Flush        = 1'b1;
        if4.Entrada  = 12'h3EE;
        #1;
        chk("t5_flush_in_ready", if4.in_ready, 1'b0);
        tick();
        Flush         = 1'b0;
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b1;
        #1;
        chk("t5_after_out_valid", if4.out_valid, 1'b0);
`ifdef REGISTRO_OCUPACION_EN
        chk("t5_after_ocup", ocup4, 3'd0);
        chk("t5_after_vacio", vacio4, 1'b1);
`endif
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("t5_no_ghost", if4.out_valid, 1'b0);
        end
        if4.in_valid = 1'b1;
        if4.Entrada  = 12'h3AA;
        tick();
        if4.in_valid = 1'b0;
        n = 0;
        while (!if4.out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("t5_latency_d4", n, 3);
        chk("t5_salida", if4.Salida, 12'h3AA);
        tick();
        chk("t5_single", if4.out_valid, 1'b0);

        // T6: reset mid-stream with Enable=0 and Flush=1 at the same time
        do_reset();
        if2.out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            if2.in_valid = 1'b1;
            if2.Entrada  = 12'(12'h401 + j);
            tick();
        end
        chk("t6_pre_out_valid", if2.out_valid, 1'b1);
        Reset       = 1'b1;
        Enable      = 1'b0;
        Flush       = 1'b1;
        if2.Entrada = 12'h4FF;
        #1;
        chk("t6_in_ready_rst", if2.in_ready, 1'b0);
        tick();
        chk("t6_out_valid", if2.out_valid, 1'b0);
        chk("t6_salida", if2.Salida, 12'h000);
        chk("t6_in_ready_rst_b", if2.in_ready, 1'b0);
`ifdef REGISTRO_OCUPACION_EN
        chk("t6_vacio", vacio2, 1'b1);
        chk("t6_ocup", ocup2, 2'd0);
        chk("t6_lleno", lleno2, 1'b0);
`endif

        // T3: random traffic on D=4 against a FIFO model
        do_reset();
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            en   = ($urandom_range(0, 7) != 0);
            Enable        = en;
            if4.in_valid  = iv;
            if4.Entrada   = 12'($urandom);
            if4.out_ready = ordy;
            #1;
            exp_ir = en && ((q.size() < 4) || ordy);
            chk("t3_in_ready", if4.in_ready, exp_ir);
            if (q.size() == 0) chk("t3_empty_out_valid", if4.out_valid, 1'b0);
            if (q.size() == 4) chk("t3_full_out_valid", if4.out_valid, 1'b1);
`ifdef REGISTRO_OCUPACION_EN
            chk("t3_ocup", ocup4, 3'(q.size()));
            chk("t3_lleno", lleno4, (q.size() == 4));
            chk("t3_vacio", vacio4, (q.size() == 0));
`endif
            if (en && ordy && if4.out_valid) begin
                chk("t3_pop_nonempty", (q.size() != 0), 1'b1);
                if (q.size() != 0) chk("t3_salida", if4.Salida, q.pop_front());
            end
            if (iv && exp_ir) q.push_back(int'(if4.Entrada));
            tick();
        end
        Enable        = 1'b1;
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            #1;
            if (if4.out_valid) chk("t3_drain_salida", if4.Salida, q.pop_front());
            tick();
        end
        chk("t3_drained", q.size(), 0);
        #1;
        chk("t3_drained_out_valid", if4.out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
